// File: rtl/pipeline_stall_top_p.sv
// Stall-able pipeline feeding a shared-resource buffer with occupancy-driven global stall.
// Optional STALL_CNT_EN adds a saturating stall_cycles counter output.
module pipeline_stall_top_p #(
   parameter int WIDTH        = 32,
   parameter int STAGES       = 3,
   parameter int DEPTH        = 4,
   parameter int STALL_THRESH = DEPTH - 1,
   parameter int RES_LATENCY  = 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [WIDTH-1:0]           inputs,
   input  logic                       in_valid,
   input  logic                       flush,
   input  logic                       arbiter_grant,
   input  logic [WIDTH-1:0]           resource_output,
   output logic [WIDTH-1:0]           outputs,
   output logic                       out_valid,
   output logic                       arbiter_req,
   output logic [WIDTH-1:0]           resource_input,
   output logic                       stall_signal,
`ifdef STALL_CNT_EN
   output logic [31:0]                stall_cycles,
`endif
   output logic [$clog2(DEPTH+1)-1:0] buffer_level
);

   localparam int LW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0]   stage_data_reg [STAGES];
   logic               stage_valid_reg [STAGES];
   logic [WIDTH-1:0]   mem [DEPTH];
   logic [PW-1:0]      wr_ptr_reg, wr_ptr_next;
   logic [PW-1:0]      rd_ptr_reg, rd_ptr_next;
   logic [LW-1:0]      level_reg, level_next;
   logic [RES_LATENCY-1:0] inflight_reg;
   logic               push;
   logic               pop;

   // Stall is a pure decode of the registered occupancy, so it never depends on inputs.
   assign stall_signal = (level_reg >= LW'(STALL_THRESH));
   assign buffer_level = level_reg;
   assign arbiter_req  = (level_reg != '0) && !flush;
   assign pop          = arbiter_req && arbiter_grant;
   assign push         = stage_valid_reg[STAGES-1] && !stall_signal && !flush;

   genvar gi;
   generate
      for (gi = 0; gi < STAGES; gi++) begin : g_stage
         logic [WIDTH-1:0] d_src;
         logic             v_src;
         if (gi == 0) begin : g_first
            assign d_src = inputs;
            assign v_src = in_valid;
         end else begin : g_rest
            assign d_src = stage_data_reg[gi-1];
            assign v_src = stage_valid_reg[gi-1];
         end

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               stage_valid_reg[gi] <= 1'b0;
               stage_data_reg[gi]  <= '0;
            end else if (flush) begin
               stage_valid_reg[gi] <= 1'b0;
            end else if (!stall_signal) begin
               stage_valid_reg[gi] <= v_src;
               stage_data_reg[gi]  <= d_src;
            end
         end
      end
   endgenerate

   // Pointers wrap explicitly so non-power-of-two depths work.
   always_comb begin
      wr_ptr_next = wr_ptr_reg;
      rd_ptr_next = rd_ptr_reg;
      level_next  = level_reg;
      if (push) begin
         wr_ptr_next = (wr_ptr_reg == PW'(DEPTH - 1)) ? '0 : wr_ptr_reg + PW'(1);
      end
      if (pop) begin
         rd_ptr_next = (rd_ptr_reg == PW'(DEPTH - 1)) ? '0 : rd_ptr_reg + PW'(1);
      end
      if (push && !pop) begin
         level_next = level_reg + LW'(1);
      end else if (!push && pop) begin
         level_next = level_reg - LW'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
      end else if (flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
         level_reg  <= level_next;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_reg] <= stage_data_reg[STAGES-1];
      end
   end

   assign resource_input = mem[rd_ptr_reg];

   // One bit per outstanding resource op; the tail marks the result cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         inflight_reg <= '0;
      end else if (flush) begin
         inflight_reg <= '0;
      end else begin
         inflight_reg[0] <= pop;
         for (int i = 1; i < RES_LATENCY; i++) begin
            inflight_reg[i] <= inflight_reg[i-1];
         end
      end
   end

   assign out_valid = inflight_reg[RES_LATENCY-1] && !flush;
   assign outputs   = resource_output;

`ifdef STALL_CNT_EN
   logic [31:0] stall_cnt_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt_reg <= '0;
      end else if (stall_signal && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
         stall_cnt_reg <= stall_cnt_reg + 32'd1;
      end
   end

   assign stall_cycles = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_pipeline_stall_top_p.sv
// Bench for pipeline_stall_top_p: instance A uses defaults, instance B is DEPTH=3/RES_LATENCY=2.
// Shared stimulus; sel picks which instance the scoreboard watches.
module tb_pipeline_stall_top_p;

   logic        clk;
   logic        reset;
   logic [31:0] inputs;
   logic        in_valid;
   logic        flush;
   logic        arbiter_grant;
   logic        sel;

   logic [31:0] a_out, a_rin, a_rout, b_out, b_rin, b_rout;
   logic        a_ov, a_req, a_stall, b_ov, b_req, b_stall;
   logic [2:0]  a_lvl;
   logic [1:0]  b_lvl;
`ifdef STALL_CNT_EN
   logic [31:0] a_cnt, b_cnt;
`endif

   pipeline_stall_top_p u_a (
      .clk(clk), .reset(reset), .inputs(inputs), .in_valid(in_valid), .flush(flush),
      .arbiter_grant(arbiter_grant), .resource_output(a_rout), .outputs(a_out),
      .out_valid(a_ov), .arbiter_req(a_req), .resource_input(a_rin),
      .stall_signal(a_stall),
`ifdef STALL_CNT_EN
      .stall_cycles(a_cnt),
`endif
      .buffer_level(a_lvl)
   );

   pipeline_stall_top_p #(.WIDTH(32), .STAGES(2), .DEPTH(3), .STALL_THRESH(3), .RES_LATENCY(2)) u_b (
      .clk(clk), .reset(reset), .inputs(inputs), .in_valid(in_valid), .flush(flush),
      .arbiter_grant(arbiter_grant), .resource_output(b_rout), .outputs(b_out),
      .out_valid(b_ov), .arbiter_req(b_req), .resource_input(b_rin),
      .stall_signal(b_stall),
`ifdef STALL_CNT_EN
      .stall_cycles(b_cnt),
`endif
      .buffer_level(b_lvl)
   );

   // Echo resources: the operand popped at an edge returns after the instance's latency.
   logic [31:0] ra_q, rb_q0, rb_q1;
   always @(posedge clk) begin
      ra_q  <= a_rin;
      rb_q0 <= b_rin;
      rb_q1 <= rb_q0;
   end
   assign a_rout = ra_q;
   assign b_rout = rb_q1;

   logic [31:0] m_out;
   logic        m_ov, m_req, m_stall;
   logic [2:0]  m_lvl;
   assign m_out   = sel ? b_out   : a_out;
   assign m_ov    = sel ? b_ov    : a_ov;
   assign m_req   = sel ? b_req   : a_req;
   assign m_stall = sel ? b_stall : a_stall;
   assign m_lvl   = sel ? {1'b0, b_lvl} : a_lvl;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          tests = 0;
   int          fails = 0;
   int          out_cnt = 0;
   logic [31:0] exp_q [$];

   typedef struct {
      logic        iv;
      logic [31:0] d;
      logic        g;
      logic [2:0]  lvl;
      logic        st;
      logic        rq;
      logic        ov;
   } vec_t;
   vec_t tbl [15];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      in_valid = 1'b0;
      flush = 1'b0;
      arbiter_grant = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      exp_q.delete();
   endtask

   // One clock: drive at negedge, score the accepted input, sample outputs 1 after posedge.
   task automatic cycle(input logic iv, input logic [31:0] d, input logic g, input logic fl,
                        output logic took);
      logic [31:0] e;
      @(negedge clk);
      in_valid = iv;
      inputs = d;
      arbiter_grant = g;
      flush = fl;
      #1;
      if (fl) exp_q.delete();
      took = iv && !m_stall && !fl;
      if (took) exp_q.push_back(d);
      @(posedge clk);
      #1;
      if (m_ov) begin
         out_cnt++;
         if (exp_q.size() == 0) begin
            check("unexpected_out_valid", m_out, 32'hDEAD_BEEF);
         end else begin
            e = exp_q.pop_front();
            $display("[TB] out %0h expected %0h level %0d", m_out, e, m_lvl);
            check("out_data", m_out, e);
         end
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic took;
      logic g;
      int   idx, cyc, maxl, base;

      reset = 1'b1;
      inputs = '0;
      in_valid = 1'b0;
      flush = 1'b0;
      arbiter_grant = 1'b0;
      sel = 1'b0;

      // Fill with grant low, then drain with an echoing resource.
      tbl[0]  = '{1'b1, 32'd1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0};
      tbl[1]  = '{1'b1, 32'd2, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0};
      tbl[2]  = '{1'b1, 32'd3, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0};
      tbl[3]  = '{1'b1, 32'd4, 1'b0, 3'd1, 1'b0, 1'b1, 1'b0};
      tbl[4]  = '{1'b1, 32'd5, 1'b0, 3'd2, 1'b0, 1'b1, 1'b0};
      tbl[5]  = '{1'b1, 32'd6, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0};
      tbl[6]  = '{1'b0, 32'd0, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0};
      tbl[7]  = '{1'b0, 32'd0, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0};
      tbl[8]  = '{1'b0, 32'd0, 1'b1, 3'd2, 1'b0, 1'b1, 1'b1};
      tbl[9]  = '{1'b0, 32'd0, 1'b1, 3'd2, 1'b0, 1'b1, 1'b1};
      tbl[10] = '{1'b0, 32'd0, 1'b1, 3'd2, 1'b0, 1'b1, 1'b1};
      tbl[11] = '{1'b0, 32'd0, 1'b1, 3'd2, 1'b0, 1'b1, 1'b1};
      tbl[12] = '{1'b0, 32'd0, 1'b1, 3'd1, 1'b0, 1'b1, 1'b1};
      tbl[13] = '{1'b0, 32'd0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1};
      tbl[14] = '{1'b0, 32'd0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0};

      do_reset();
      check("reset_level_a", 32'(a_lvl), 32'd0);
      check("reset_stall_a", 32'(a_stall), 32'd0);
      check("reset_req_a", 32'(a_req), 32'd0);
      check("reset_ov_a", 32'(a_ov), 32'd0);
      check("reset_level_b", 32'(b_lvl), 32'd0);
`ifdef STALL_CNT_EN
      check("reset_stall_cycles", a_cnt, 32'd0);
`endif

      sel = 1'b0;
      for (int r = 0; r < 15; r++) begin
         cycle(tbl[r].iv, tbl[r].d, tbl[r].g, 1'b0, took);
         check($sformatf("tbl%0d_level", r), 32'(m_lvl), 32'(tbl[r].lvl));
         check($sformatf("tbl%0d_stall", r), 32'(m_stall), 32'(tbl[r].st));
         check($sformatf("tbl%0d_req", r), 32'(m_req), 32'(tbl[r].rq));
         check($sformatf("tbl%0d_ov", r), 32'(m_ov), 32'(tbl[r].ov));
      end
      check("drain_all_out", 32'(exp_q.size()), 32'd0);

      // Pointer wrap on the DEPTH=3 instance with irregular grants.
      sel = 1'b1;
      do_reset();
      idx = 0;
      cyc = 0;
      maxl = 0;
      base = out_cnt;
      while ((idx < 20 || exp_q.size() != 0) && cyc < 400) begin
         g = (cyc < 10) ? 1'b0 : 1'($urandom_range(0, 1));
         cycle(idx < 20, 32'(100 + idx), g, 1'b0, took);
         if (took) idx++;
         if (int'(m_lvl) > maxl) maxl = int'(m_lvl);
         cyc++;
      end
      check("wrap_within_budget", 32'(cyc < 400), 32'd1);
      check("wrap_items_accepted", 32'(idx), 32'd20);
      check("wrap_items_out", 32'(out_cnt - base), 32'd20);
      check("wrap_max_level", 32'(maxl), 32'd3);

      // Flush with level 2, both stages valid and one op in flight.
      do_reset();
      cycle(1'b1, 32'd11, 1'b0, 1'b0, took);
      cycle(1'b1, 32'd12, 1'b0, 1'b0, took);
      cycle(1'b1, 32'd13, 1'b0, 1'b0, took);
      cycle(1'b1, 32'd14, 1'b0, 1'b0, took);
      cycle(1'b1, 32'd15, 1'b1, 1'b0, took);
      check("preflush_level", 32'(m_lvl), 32'd2);
      check("preflush_req", 32'(m_req), 32'd1);
      @(negedge clk);
      in_valid = 1'b1;
      inputs = 32'd99;
      flush = 1'b1;
      arbiter_grant = 1'b1;
      #1;
      exp_q.delete();
      check("flush_cycle_req", 32'(m_req), 32'd0);
      check("flush_cycle_ov", 32'(m_ov), 32'd0);
      @(posedge clk);
      #1;
      check("postflush_level", 32'(m_lvl), 32'd0);
      check("postflush_stall", 32'(m_stall), 32'd0);
      base = out_cnt;
      for (int k = 0; k < 6; k++) cycle(1'b0, 32'd0, 1'b1, 1'b0, took);
      check("postflush_no_out", 32'(out_cnt - base), 32'd0);
      check("postflush_req", 32'(m_req), 32'd0);
      check("flush_input_dropped", 32'(m_lvl), 32'd0);

      // Async reset between edges while draining.
      sel = 1'b0;
      do_reset();
      for (int k = 1; k <= 3; k++) cycle(1'b1, 32'(k), 1'b0, 1'b0, took);
      for (int k = 0; k < 3; k++) cycle(1'b0, 32'd0, 1'b0, 1'b0, took);
      cycle(1'b0, 32'd0, 1'b1, 1'b0, took);
      cycle(1'b0, 32'd0, 1'b1, 1'b0, took);
      check("prereset_level", 32'(m_lvl), 32'd1);
      check("prereset_ov", 32'(m_ov), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      check("async_level", 32'(m_lvl), 32'd0);
      check("async_ov", 32'(m_ov), 32'd0);
      check("async_req", 32'(m_req), 32'd0);
      check("async_stall", 32'(m_stall), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      arbiter_grant = 1'b0;
      exp_q.delete();
      cycle(1'b1, 32'h55, 1'b0, 1'b0, took);
      check("relat_e1", 32'(m_lvl), 32'd0);
      cycle(1'b0, 32'd0, 1'b0, 1'b0, took);
      check("relat_e2", 32'(m_lvl), 32'd0);
      cycle(1'b0, 32'd0, 1'b0, 1'b0, took);
      check("relat_e3", 32'(m_lvl), 32'd0);
      cycle(1'b0, 32'd0, 1'b0, 1'b0, took);
      check("relat_e4", 32'(m_lvl), 32'd1);
      base = out_cnt;
      cycle(1'b0, 32'd0, 1'b1, 1'b0, took);
      cycle(1'b0, 32'd0, 1'b0, 1'b0, took);
      check("relat_out_count", 32'(out_cnt - base), 32'd1);
      check("relat_queue_empty", 32'(exp_q.size()), 32'd0);

      // Flush while stalled: state clears; stall counter keeps its value.
      do_reset();
      for (int k = 1; k <= 6; k++) cycle(1'b1, 32'(k), 1'b0, 1'b0, took);
      for (int k = 0; k < 9; k++) cycle(1'b0, 32'd0, 1'b0, 1'b0, took);
      check("stalled_before_flush", 32'(m_stall), 32'd1);
      cycle(1'b0, 32'd0, 1'b0, 1'b1, took);
      for (int k = 0; k < 3; k++) cycle(1'b0, 32'd0, 1'b0, 1'b0, took);
      check("flush_stall_level", 32'(m_lvl), 32'd0);
      check("flush_stall_stall", 32'(m_stall), 32'd0);
`ifdef STALL_CNT_EN
      check("stall_cycles_after_flush", a_cnt, 32'd10);
      do_reset();
      check("stall_cycles_after_reset", a_cnt, 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
